// File: rtl/sha_pad.sv
// SHA-256 message padder: packs a byte-granular word stream into 512-bit blocks for sha_core.
// Blocks are issued as single-cycle strobes spaced at least GAP cycles apart.
module sha_pad #(
   parameter int unsigned GAP = 64
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         s_valid,
   output logic         s_ready,
   input  logic [31:0]  s_data,
   input  logic         s_last,
   input  logic [2:0]   s_nbytes,
   output logic         blk_valid,
   output logic [1:0]   mode,
   output logic [511:0] message,
   output logic         blk_last,
   output logic         busy
);

   localparam logic [1:0] StFill  = 2'd0;
   localparam logic [1:0] StWait  = 2'd1;
   localparam logic [1:0] StIssue = 2'd2;

   localparam logic PendData  = 1'b0;
   localparam logic PendFinal = 1'b1;

   localparam logic [7:0] GapCnt = 8'(GAP);

   logic [1:0]   r_state;
   logic         r_run;
   logic [511:0] r_msg;
   logic [3:0]   r_wi;
   logic [60:0]  r_len;
   logic         r_first;
   logic         r_pend;
   logic [1:0]   r_xtra;
   logic [7:0]   r_gc;
   logic         r_busy;

   logic         w_acc;
   logic [2:0]   w_nb;
   logic [60:0]  w_len_new;
   logic [3:0]   w_wi_p1;
   logic [4:0]   w_w80;
   logic [31:0]  w_tail;
   logic [8:0]   w_pos;
   logic [8:0]   w_pos_p1;

   always_comb begin
      w_acc     = s_valid && s_ready;
      w_nb      = (s_nbytes > 3'd4) ? 3'd4 : s_nbytes;
      w_len_new = r_len + 61'(w_nb);
      w_wi_p1   = r_wi + 4'd1;
      w_w80     = (w_nb == 3'd4) ? ({1'b0, r_wi} + 5'd1) : {1'b0, r_wi};
      // Word i lives at bit offset (15-i)*32, and 15-i is simply ~i for a 4-bit index.
      w_pos     = {~r_wi, 5'd0};
      w_pos_p1  = {~w_wi_p1, 5'd0};
      w_tail    = '0;
      for (int b = 0; b < 4; b++) begin
         if (3'(b) < w_nb) begin
            w_tail[31-8*b -: 8] = s_data[31-8*b -: 8];
         end else if (3'(b) == w_nb) begin
            w_tail[31-8*b -: 8] = 8'h80;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= StFill;
         r_run   <= 1'b0;
         r_msg   <= '0;
         r_wi    <= '0;
         r_len   <= '0;
         r_first <= 1'b1;
         r_pend  <= PendData;
         r_xtra  <= '0;
         r_gc    <= GapCnt;
         r_busy  <= 1'b0;
      end else begin
         r_run <= 1'b1;

         if (r_state == StIssue) begin
            r_gc <= 8'd1;
         end else if (r_gc < GapCnt) begin
            r_gc <= r_gc + 8'd1;
         end

         case (r_state)
            StFill: begin
               if (w_acc) begin
                  r_busy <= 1'b1;
                  r_len  <= w_len_new;
                  r_wi   <= w_wi_p1;
                  if (!s_last) begin
                     r_msg[w_pos +: 32] <= s_data;
                     if (r_wi == 4'd15) begin
                        r_pend  <= PendData;
                        r_state <= StWait;
                     end
                  end else begin
                     r_msg[w_pos +: 32] <= w_tail;
                     if (w_nb == 3'd4 && r_wi != 4'd15) begin
                        r_msg[w_pos_p1 +: 32] <= 32'h8000_0000;
                     end
                     r_state <= StWait;
                     if (w_w80 <= 5'd13) begin
                        r_msg[63:0] <= {w_len_new, 3'b000};
                        r_pend      <= PendFinal;
                     end else begin
                        // No room for the length: an extra block follows, carrying the
                        // 0x80 marker too when it did not fit in this one.
                        r_pend <= PendData;
                        r_xtra <= (w_w80 == 5'd16) ? 2'd2 : 2'd1;
                     end
                  end
               end
            end

            StWait: begin
               if (r_gc >= GapCnt) begin
                  r_state <= StIssue;
               end
            end

            StIssue: begin
               r_first <= 1'b0;
               if (r_xtra != 2'd0) begin
                  r_msg   <= {((r_xtra == 2'd2) ? 32'h8000_0000 : 32'h0), 416'd0, r_len, 3'b000};
                  r_pend  <= PendFinal;
                  r_xtra  <= 2'd0;
                  r_state <= StWait;
               end else begin
                  r_msg   <= '0;
                  r_wi    <= '0;
                  r_state <= StFill;
                  if (r_pend == PendFinal) begin
                     r_first <= 1'b1;
                     r_len   <= '0;
                     r_busy  <= 1'b0;
                  end
               end
            end

            default: begin
               r_state <= StFill;
            end
         endcase
      end
   end

   assign s_ready   = r_run && (r_state == StFill);
   assign blk_valid = (r_state == StIssue);
   assign mode      = {1'b0, blk_valid & r_first};
   assign blk_last  = blk_valid & (r_pend == PendFinal);
   assign message   = r_msg;
   assign busy      = r_busy;

`ifndef SYNTHESIS
   a_strobe_single : assert property (@(posedge clk) disable iff (!reset_n)
      blk_valid |=> !blk_valid);
   a_no_ready_on_issue : assert property (@(posedge clk) disable iff (!reset_n)
      blk_valid |-> !s_ready);
   a_gc_bounded : assert property (@(posedge clk) disable iff (!reset_n)
      r_gc <= GapCnt);
   a_state_legal : assert property (@(posedge clk) disable iff (!reset_n)
      r_state != 2'd3);
`endif

endmodule

// File: tb/tb_sha_pad.sv
// Self-checking bench for sha_pad: table of messages plus reset/back-to-back sequences,
// with a reference padder feeding an expected-block scoreboard.
module tb_sha_pad;

   localparam int unsigned GAP = 64;

   logic         clk      = 1'b0;
   logic         reset_n  = 1'b0;
   logic         s_valid  = 1'b0;
   logic [31:0]  s_data   = '0;
   logic         s_last   = 1'b0;
   logic [2:0]   s_nbytes = '0;
   logic         s_ready;
   logic         blk_valid;
   logic [1:0]   mode;
   logic [511:0] message;
   logic         blk_last;
   logic         busy;

   sha_pad #(.GAP(GAP)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .s_data    (s_data),
      .s_last    (s_last),
      .s_nbytes  (s_nbytes),
      .blk_valid (blk_valid),
      .mode      (mode),
      .message   (message),
      .blk_last  (blk_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [511:0] msg;
      logic [1:0]   mode;
      logic         last;
   } blk_t;

   typedef struct {
      int          n;
      bit          term;
      bit          ovf;
      int          exp_blocks;
      logic [31:0] exp_first_w0;
      logic [31:0] exp_last_w0;
      logic [31:0] exp_last_w15;
   } vec_t;

   blk_t        sb[$];
   int          blk_cnt    = 0;
   logic [31:0] first_w0   = '0;
   logic [31:0] last_w0    = '0;
   logic [31:0] last_w15   = '0;
   int          prev_cyc   = 0;
   bit          have_prev  = 1'b0;
   int          strobe_cyc = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_msg(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference padding: message bytes are 0x61 + index ("abc..." for short messages).
   task automatic push_expected(input int n);
      byte unsigned pad[$];
      logic [63:0]  bits;
      blk_t         e;
      int           nblk;
      for (int k = 0; k < n; k++) pad.push_back(8'(8'h61 + k));
      pad.push_back(8'h80);
      while (pad.size() % 64 != 56) pad.push_back(8'h00);
      bits = 64'(n) * 64'd8;
      for (int b = 7; b >= 0; b--) pad.push_back(bits[8*b +: 8]);
      nblk = pad.size() / 64;
      for (int i = 0; i < nblk; i++) begin
         e.msg = '0;
         for (int j = 0; j < 64; j++) e.msg[511-8*j -: 8] = pad[64*i+j];
         e.mode = (i == 0) ? 2'd1 : 2'd0;
         e.last = (i == nblk - 1);
         sb.push_back(e);
      end
   endtask

   function automatic logic [31:0] word_at(input int n, input int i);
      logic [31:0] w;
      for (int b = 0; b < 4; b++) begin
         w[31-8*b -: 8] = (4*i + b < n) ? 8'(8'h61 + 4*i + b) : 8'hA5;
      end
      return w;
   endfunction

   task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb,
                            output int acc_cyc);
      int t;
      t = 0;
      @(negedge clk);
      s_valid  = 1'b1;
      s_data   = d;
      s_last   = last;
      s_nbytes = nb;
      while (!s_ready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      if (!s_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout: got s_ready=0, expected 1 within 1000 cycles");
      end
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send_msg(input int n, input bit term, input bit ovf, output int acc_cyc);
      int nfull;
      int r;
      nfull = n / 4;
      r     = n % 4;
      if (r != 0) begin
         for (int i = 0; i < nfull; i++) send_word(word_at(n, i), 1'b0, 3'd4, acc_cyc);
         send_word(word_at(n, nfull), 1'b1, 3'(r), acc_cyc);
      end else if (term || n == 0) begin
         for (int i = 0; i < nfull; i++) send_word(word_at(n, i), 1'b0, 3'd4, acc_cyc);
         send_word(32'hDEAD_BEEF, 1'b1, 3'd0, acc_cyc);
      end else begin
         for (int i = 0; i < nfull - 1; i++) send_word(word_at(n, i), 1'b0, 3'd4, acc_cyc);
         send_word(word_at(n, nfull - 1), 1'b1, ovf ? 3'd7 : 3'd4, acc_cyc);
      end
   endtask

   task automatic wait_idle(input string name);
      int t;
      t = 0;
      @(negedge clk);
      while ((busy || sb.size() != 0) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk(name, 64'(busy || sb.size() != 0), 64'd0);
   endtask

   always @(negedge reset_n) have_prev = 1'b0;

   always @(negedge clk) begin
      if (reset_n && blk_valid) begin
         blk_t e;
         if (have_prev) chk("strobe_gap_ok", 64'(cyc - prev_cyc >= int'(GAP)), 64'd1);
         prev_cyc   = cyc;
         have_prev  = 1'b1;
         strobe_cyc = cyc;
         blk_cnt++;
         if (blk_cnt == 1) first_w0 = message[511:480];
         last_w0  = message[511:480];
         last_w15 = message[31:0];
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_block: got blk_valid=1, expected no block");
         end else begin
            e = sb.pop_front();
            chk_msg("block_message", message, e.msg);
            chk("block_mode", 64'(mode), 64'(e.mode));
            chk("block_last", 64'(blk_last), 64'(e.last));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t vecs[13];
      int   acc;

      vecs[0]  = '{0,   1'b1, 1'b0, 1, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000};
      vecs[1]  = '{3,   1'b0, 1'b0, 1, 32'h6162_6380, 32'h6162_6380, 32'h0000_0018};
      vecs[2]  = '{55,  1'b0, 1'b0, 1, 32'h6162_6364, 32'h6162_6364, 32'h0000_01B8};
      vecs[3]  = '{56,  1'b0, 1'b0, 2, 32'h6162_6364, 32'h0000_0000, 32'h0000_01C0};
      vecs[4]  = '{56,  1'b1, 1'b0, 2, 32'h6162_6364, 32'h0000_0000, 32'h0000_01C0};
      vecs[5]  = '{64,  1'b1, 1'b0, 2, 32'h6162_6364, 32'h8000_0000, 32'h0000_0200};
      vecs[6]  = '{64,  1'b0, 1'b0, 2, 32'h6162_6364, 32'h8000_0000, 32'h0000_0200};
      vecs[7]  = '{60,  1'b0, 1'b0, 2, 32'h6162_6364, 32'h0000_0000, 32'h0000_01E0};
      vecs[8]  = '{52,  1'b0, 1'b0, 1, 32'h6162_6364, 32'h6162_6364, 32'h0000_01A0};
      vecs[9]  = '{8,   1'b0, 1'b1, 1, 32'h6162_6364, 32'h6162_6364, 32'h0000_0040};
      vecs[10] = '{130, 1'b0, 1'b0, 3, 32'h6162_6364, 32'hE1E2_8000, 32'h0000_0410};
      vecs[11] = '{4,   1'b1, 1'b0, 1, 32'h6162_6364, 32'h6162_6364, 32'h0000_0020};
      vecs[12] = '{57,  1'b0, 1'b0, 2, 32'h6162_6364, 32'h0000_0000, 32'h0000_01C8};

      // Reset state
      #1;
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      chk("rst_blk_valid", 64'(blk_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_mode", 64'(mode), 64'd0);
      chk_msg("rst_message", message, 512'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_s_ready", 64'(s_ready), 64'd1);

      for (int v = 0; v < 13; v++) begin
         blk_cnt = 0;
         push_expected(vecs[v].n);
         send_msg(vecs[v].n, vecs[v].term, vecs[v].ovf, acc);
         wait_idle("msg_idle");
         chk("vec_blocks", 64'(blk_cnt), 64'(vecs[v].exp_blocks));
         chk("vec_first_w0", 64'(first_w0), 64'(vecs[v].exp_first_w0));
         chk("vec_last_w0", 64'(last_w0), 64'(vecs[v].exp_last_w0));
         chk("vec_last_w15", 64'(last_w15), 64'(vecs[v].exp_last_w15));
      end

      // Two "abc" messages back to back: both INIT, spacing checked by the monitor
      blk_cnt = 0;
      push_expected(3);
      push_expected(3);
      send_msg(3, 1'b0, 1'b0, acc);
      send_msg(3, 1'b0, 1'b0, acc);
      wait_idle("b2b_idle");
      chk("b2b_blocks", 64'(blk_cnt), 64'd2);

      // Reset in the middle of a block discards the partial message
      for (int i = 0; i < 5; i++) send_word(word_at(64, i), 1'b0, 3'd4, acc);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("midrst_s_ready", 64'(s_ready), 64'd0);
      chk("midrst_blk_valid", 64'(blk_valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      chk_msg("midrst_message", message, 512'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_ready_back", 64'(s_ready), 64'd1);
      blk_cnt = 0;
      repeat (80) @(negedge clk);
      chk("midrst_no_block", 64'(blk_cnt), 64'd0);

      // Fresh message after reset: INIT mode, strobe two cycles after the accepting cycle
      push_expected(3);
      send_msg(3, 1'b0, 1'b0, acc);
      wait_idle("post_rst_idle");
      chk("post_rst_blocks", 64'(blk_cnt), 64'd1);
      chk("post_rst_latency", 64'(strobe_cyc - acc), 64'd2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
